// File: rtl/wb_pkg.sv
// Shared Wishbone bus defaults and the arbiter state encoding.
package wb_pkg;

  localparam int WB_ADDR_WIDTH = 32;
  localparam int WB_DATA_WIDTH = 128;
  localparam int WB_SEL_WIDTH  = WB_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ABORT = 2'd2
  } arb_state_e;

endpackage : wb_pkg

// File: rtl/rr_pick.sv
// Rotating-priority picker: one-hot first requester at or after ptr_i, wrapping.
module rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0]                         req_i,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0] ptr_i,
  output logic [N-1:0]                         pick_o,
  output logic                                 valid_o
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W:0] idx;

  // NOTE: every variable assigned in a combinational block gets a default
  // first, so no path leaves it holding its old value (which would be a latch).
  always_comb begin
    pick_o  = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      idx = {1'b0, ptr_i} + (PTR_W + 1)'(i);
      if (idx >= (PTR_W + 1)'(N)) idx = idx - (PTR_W + 1)'(N);
      if (!valid_o && req_i[idx[PTR_W-1:0]]) begin
        pick_o[idx[PTR_W-1:0]] = 1'b1;
        valid_o                = 1'b1;
      end
    end
  end

endmodule : rr_pick

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B4 classic arbiter: grant held for a whole cyc tenure,
// watchdog aborts a hung slave with err.
module wb_rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int DATA_WIDTH  = wb_pkg::WB_DATA_WIDTH,
  parameter int ADDR_WIDTH  = wb_pkg::WB_ADDR_WIDTH,
  parameter int SEL_WIDTH   = DATA_WIDTH / 8,
  parameter int TIMEOUT     = 255
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS-1:0]            m_cyc_i,
  input  logic [NUM_MASTERS-1:0]            m_stb_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
  input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel_i,
  output logic [DATA_WIDTH-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [NUM_MASTERS-1:0]            m_err_o,
  output logic [NUM_MASTERS-1:0]            m_rty_o,
  output logic                              s_cyc_o,
  output logic                              s_stb_o,
  output logic                              s_we_o,
  output logic [ADDR_WIDTH-1:0]             s_adr_o,
  output logic [DATA_WIDTH-1:0]             s_dat_o,
  output logic [SEL_WIDTH-1:0]              s_sel_o,
  input  logic [DATA_WIDTH-1:0]             s_dat_i,
  input  logic                              s_ack_i,
  input  logic                              s_err_i,
  input  logic                              s_rty_i,
  output logic [NUM_MASTERS-1:0]            grant_o,
  output logic                              timeout_o
);

  import wb_pkg::*;

  localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [WD_W-1:0]        wdog_q, wdog_d;

  logic [NUM_MASTERS-1:0] pick;
  logic                   pick_valid;
  logic [PTR_W-1:0]       grant_idx, next_ptr;
  logic                   g_cyc, g_stb, g_we, in_grant, s_term, stalled;

  rr_pick #(.N(NUM_MASTERS)) u_pick (
    .req_i   (m_cyc_i),
    .ptr_i   (ptr_q),
    .pick_o  (pick),
    .valid_o (pick_valid)
  );

  // AND-OR mux over the one-hot grant: everything reads zero while idle.
  always_comb begin
    g_cyc     = 1'b0;
    g_stb     = 1'b0;
    g_we      = 1'b0;
    grant_idx = '0;
    s_adr_o   = '0;
    s_dat_o   = '0;
    s_sel_o   = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (grant_q[k]) begin
        g_cyc     |= m_cyc_i[k];
        g_stb     |= m_stb_i[k];
        g_we      |= m_we_i[k];
        grant_idx |= PTR_W'(k);
        s_adr_o   |= m_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        s_dat_o   |= m_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
        s_sel_o   |= m_sel_i[k*SEL_WIDTH +: SEL_WIDTH];
      end
    end
  end

  assign in_grant  = (state_q == GRANT);
  assign s_cyc_o   = in_grant & g_cyc;
  assign s_stb_o   = in_grant & g_cyc & g_stb;
  assign s_we_o    = g_we;
  assign s_term    = s_ack_i | s_err_i | s_rty_i;
  assign stalled   = s_stb_o & ~s_term;
  assign m_dat_o   = s_dat_i;
  assign grant_o   = grant_q;
  assign timeout_o = (state_q == ABORT);
  assign next_ptr  = (grant_idx == PTR_W'(NUM_MASTERS - 1)) ? '0 : grant_idx + PTR_W'(1);

  // Slave terminations reach only the granted master, and never during ABORT.
  assign m_ack_o = in_grant ? (grant_q & {NUM_MASTERS{s_ack_i}}) : '0;
  assign m_rty_o = in_grant ? (grant_q & {NUM_MASTERS{s_rty_i}}) : '0;
  assign m_err_o = in_grant  ? (grant_q & {NUM_MASTERS{s_err_i}}) :
                   timeout_o ? grant_q : '0;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    wdog_d  = '0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!g_cyc) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = next_ptr;
        end else if (stalled) begin
          wdog_d = wdog_q + WD_W'(1);
          if (TIMEOUT > 0 && wdog_q == WD_W'(TIMEOUT - 1)) state_d = ABORT;
        end
      end
      ABORT: begin
        state_d = IDLE;
        grant_d = '0;
        ptr_d   = next_ptr;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order; all control flops are
  // reset since their value right after reset is architecturally visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      wdog_q  <= wdog_d;
    end
  end

endmodule : wb_rr_arbiter

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter (2 masters, watchdog TIMEOUT=4).
module tb_wb_rr_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 128;
  localparam int SW = 16;

  logic            clk, rst;
  logic [N-1:0]    m_cyc_i, m_stb_i, m_we_i;
  logic [N*AW-1:0] m_adr_i;
  logic [N*DW-1:0] m_dat_i;
  logic [N*SW-1:0] m_sel_i;
  logic [DW-1:0]   m_dat_o;
  logic [N-1:0]    m_ack_o, m_err_o, m_rty_o;
  logic            s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]   s_adr_o;
  logic [DW-1:0]   s_dat_o;
  logic [SW-1:0]   s_sel_o;
  logic [DW-1:0]   s_dat_i;
  logic            s_ack_i, s_err_i, s_rty_i;
  logic [N-1:0]    grant_o;
  logic            timeout_o;

  int errors = 0;
  int checks = 0;
  int cnt0, cnt1;
  logic [1:0] exp_g;

  wb_rr_arbiter #(
    .NUM_MASTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SEL_WIDTH(SW), .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_m(input int k, input logic cyc, input logic stb, input logic [31:0] adr);
    m_cyc_i[k]           = cyc;
    m_stb_i[k]           = stb;
    m_we_i[k]            = 1'b0;
    m_adr_i[k*AW +: AW]  = adr;
    m_dat_i[k*DW +: DW]  = {4{adr}};
    m_sel_i[k*SW +: SW]  = '1;
  endtask

  task automatic wait_grant(input string tag, input logic [1:0] exp, input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (grant_o !== 2'b00) break;
    end
    check(tag, grant_o, exp);
  endtask

  initial begin
    rst = 1'b1;
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
    s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;

    // Reset state
    #1;
    check("rst_grant", grant_o, 0);
    check("rst_scyc", s_cyc_o, 0);
    check("rst_sstb", s_stb_o, 0);
    check("rst_ack", m_ack_o, 0);
    check("rst_err", m_err_o, 0);
    check("rst_rty", m_rty_o, 0);
    check("rst_timeout", timeout_o, 0);
    check("rst_sadr", s_adr_o, 0);
    tick(); tick();
    rst = 1'b0;

    // Single master 1
    set_m(1, 1'b1, 1'b1, 32'h0000_1000);
    settle();
    check("single_nogrant_c0", grant_o, 2'b00);
    tick();
    check("single_grant", grant_o, 2'b10);
    check("single_sadr", s_adr_o, 32'h0000_1000);
    check("single_sstb", s_stb_o, 1);
    tick(); tick();
    s_ack_i = 1'b1;
    s_dat_i = {4{32'hDEADBEEF}};
    settle();
    check("single_ack", m_ack_o, 2'b10);
    check("single_dat", m_dat_o, {4{32'hDEADBEEF}});
    tick();
    s_ack_i = 1'b0;
    set_m(1, 1'b0, 1'b0, 32'h0000_1000);
    tick();
    check("single_release", grant_o, 2'b00);

    // Simultaneous requests
    set_m(0, 1'b1, 1'b1, 32'h0000_2000);
    set_m(1, 1'b1, 1'b1, 32'h0000_3000);
    tick();
    check("simul_first", grant_o, 2'b01);
    check("simul_sadr0", s_adr_o, 32'h0000_2000);
    s_ack_i = 1'b1; settle();
    check("simul_ack0", m_ack_o, 2'b01);
    tick();
    s_ack_i = 1'b0;
    set_m(0, 1'b0, 1'b0, 32'h0000_2000);
    settle();
    check("simul_scyc_drop", s_cyc_o, 0);
    tick();
    check("simul_idle_gap", grant_o, 2'b00);
    tick();
    check("simul_second", grant_o, 2'b10);
    check("simul_sadr1", s_adr_o, 32'h0000_3000);
    s_ack_i = 1'b1; settle();
    check("simul_ack1", m_ack_o, 2'b10);
    check("simul_no_ack0", m_ack_o[0], 0);
    tick();
    s_ack_i = 1'b0;
    set_m(1, 1'b0, 1'b0, 32'h0000_3000);
    tick();

    // Eight back-to-back tenures, both masters always requesting
    cnt0 = 0; cnt1 = 0;
    set_m(0, 1'b1, 1'b1, 32'h0000_A000);
    set_m(1, 1'b1, 1'b1, 32'h0000_B000);
    for (int t = 0; t < 8; t++) begin
      exp_g = (t % 2 == 1) ? 2'b10 : 2'b01;
      wait_grant("rr_grant", exp_g, 4);
      if (grant_o == 2'b01) cnt0++;
      if (grant_o == 2'b10) cnt1++;
      s_ack_i = 1'b1; settle();
      check("rr_ack", m_ack_o, exp_g);
      tick();
      s_ack_i = 1'b0;
      m_cyc_i[t % 2] = 1'b0;
      m_stb_i[t % 2] = 1'b0;
      tick();
      check("rr_idle", grant_o, 2'b00);
      if (t < 7) begin
        m_cyc_i[t % 2] = 1'b1;
        m_stb_i[t % 2] = 1'b1;
      end else begin
        m_cyc_i = '0;
        m_stb_i = '0;
      end
    end
    check("rr_count0", cnt0, 4);
    check("rr_count1", cnt1, 4);

    // Watchdog: slave never terminates
    set_m(0, 1'b1, 1'b1, 32'h0000_4000);
    set_m(1, 1'b1, 1'b1, 32'h0000_5000);
    tick();
    check("wd_grant", grant_o, 2'b01);
    check("wd_stb_rise", s_stb_o, 1);
    check("wd_no_to_g0", timeout_o, 0);
    tick(); tick(); tick();
    check("wd_no_to_g3", timeout_o, 0);
    tick();
    s_ack_i = 1'b1; settle();
    check("wd_timeout", timeout_o, 1);
    check("wd_err", m_err_o, 2'b01);
    check("wd_scyc", s_cyc_o, 0);
    check("wd_sstb", s_stb_o, 0);
    check("wd_ack_ignored", m_ack_o, 2'b00);
    tick();
    s_ack_i = 1'b0;
    set_m(0, 1'b0, 1'b0, 32'h0000_4000);
    settle();
    check("wd_idle", grant_o, 2'b00);
    check("wd_pulse_end", timeout_o, 0);
    tick();
    check("wd_next_grant", grant_o, 2'b10);
    s_ack_i = 1'b1; settle();
    check("wd_next_ack", m_ack_o, 2'b10);
    tick();
    s_ack_i = 1'b0;
    set_m(1, 1'b0, 1'b0, 32'h0000_5000);
    tick();

    // Burst: master 0 holds cyc across 3 beats while master 1 waits
    set_m(0, 1'b1, 1'b1, 32'h0000_6000);
    set_m(1, 1'b1, 1'b1, 32'h0000_7000);
    tick();
    for (int b = 0; b < 3; b++) begin
      s_ack_i = 1'b1; settle();
      check("burst_grant", grant_o, 2'b01);
      check("burst_ack", m_ack_o, 2'b01);
      tick();
      s_ack_i = 1'b0; settle();
      check("burst_hold", grant_o, 2'b01);
      tick();
    end
    set_m(0, 1'b0, 1'b0, 32'h0000_6000);
    tick();
    check("burst_idle", grant_o, 2'b00);
    tick();
    check("burst_pass", grant_o, 2'b10);
    s_ack_i = 1'b1; settle();
    check("burst_ack1", m_ack_o, 2'b10);
    tick();
    s_ack_i = 1'b0;
    set_m(1, 1'b0, 1'b0, 32'h0000_7000);
    tick();

    // Request withdrawn after one cycle
    set_m(1, 1'b1, 1'b1, 32'h0000_8000);
    tick();
    set_m(1, 1'b0, 1'b0, 32'h0000_8000);
    settle();
    check("wd1_grant", grant_o, 2'b10);
    check("wd1_no_stb", s_stb_o, 0);
    check("wd1_no_cyc", s_cyc_o, 0);
    tick();
    check("wd1_end", grant_o, 2'b00);

    // Async reset mid-tenure; pointer left at 1 beforehand
    set_m(0, 1'b1, 1'b1, 32'h0000_9000);
    tick();
    s_ack_i = 1'b1; settle();
    tick();
    s_ack_i = 1'b0;
    set_m(0, 1'b0, 1'b0, 32'h0000_9000);
    tick();
    set_m(0, 1'b1, 1'b1, 32'h0000_9000);
    tick();
    check("ar_grant_before", grant_o, 2'b01);
    #2;
    rst = 1'b1;
    #1;
    check("ar_grant", grant_o, 2'b00);
    check("ar_scyc", s_cyc_o, 0);
    check("ar_sstb", s_stb_o, 0);
    set_m(1, 1'b1, 1'b1, 32'h0000_C000);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("ar_prio0", grant_o, 2'b01);
    m_cyc_i = '0;
    m_stb_i = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_wb_rr_arbiter

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- N-master round-robin Wishbone B4 classic arbiter that shares one external memory bus among cache-line requesters: the instruction-fetch port, the data port, and future DMA/debug masters.
- Grant is held for a master's whole cyc tenure.
- A bus-watchdog terminates a hung slave with err.
- Sits between the memory controller's bus masters and the external memory port.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (>=2).
- DATA_WIDTH, 128, bus data width (one cache line).
- ADDR_WIDTH, 32, byte address width.
- SEL_WIDTH, DATA_WIDTH/8, byte-select width.
- TIMEOUT, 255, cycles stb may wait for ack/err/rty before forced err; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- m_cyc_i  in  NUM_MASTERS  per-master cycle request
- m_stb_i  in  NUM_MASTERS  per-master strobe
- m_we_i  in  NUM_MASTERS  per-master write enable
- m_adr_i  in  NUM_MASTERS*ADDR_WIDTH  packed addresses, master k at [k*ADDR_WIDTH +: ADDR_WIDTH]
- m_dat_i  in  NUM_MASTERS*DATA_WIDTH  packed write data
- m_sel_i  in  NUM_MASTERS*SEL_WIDTH  packed byte selects
- m_dat_o  out  DATA_WIDTH  slave read data, broadcast to all masters
- m_ack_o  out  NUM_MASTERS  per-master ack
- m_err_o  out  NUM_MASTERS  per-master err (slave err or watchdog)
- m_rty_o  out  NUM_MASTERS  per-master rty
- s_cyc_o, s_stb_o, s_we_o  out  1  slave controls
- s_adr_o  out  ADDR_WIDTH  slave address
- s_dat_o  out  DATA_WIDTH  slave write data
- s_sel_o  out  SEL_WIDTH  slave byte select
- s_dat_i  in  DATA_WIDTH  slave read data
- s_ack_i, s_err_i, s_rty_i  in  1  slave terminations
- grant_o  out  NUM_MASTERS  one-hot current grant (all zero when idle)
- timeout_o  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- State machine: IDLE, GRANT, ABORT.
- Reset (async assert, released synchronously to clk) gives:
  - state=IDLE, grant_o=0, priority pointer=0 (master 0 highest), watchdog count=0, timeout_o=0.
  - All s_* controls and m_ack/err/rty outputs read 0.
- IDLE:
  - If any m_cyc_i is high, register a one-hot grant to the first requester at or after the pointer, wrapping from NUM_MASTERS-1 to 0, then go to GRANT.
  - Arbitration latency: exactly 1 cycle from m_cyc_i high to grant_o high.
  - If no request, stay in IDLE.
- GRANT:
  - s_cyc_o/s_stb_o/s_we_o/s_adr_o/s_dat_o/s_sel_o are a combinational mux of the granted master.
  - s_cyc_o and s_stb_o are gated by grant.
  - s_ack/err/rty_i route only to the granted master's bit; all other bits are 0.
- Release:
  - When the granted m_cyc_i goes low: next state IDLE, grant_o=0, pointer = granted index+1 mod NUM_MASTERS.
  - There is one idle cycle between tenures. No grant switch mid-cycle, even with multiple stb beats.
- Watchdog:
  - Counts cycles with s_stb_o high and no slave termination.
  - The count clears on any termination or when stb is low.
  - When the count reaches TIMEOUT (TIMEOUT>0), go to ABORT.
- ABORT, one cycle:
  - m_err_o of the granted master = 1 and timeout_o = 1.
  - s_cyc_o and s_stb_o = 0, and any slave termination arriving this cycle is ignored.
  - Next state IDLE; the pointer advances as on a normal release.
- Request withdrawn before grant (cyc pulse of 1 cycle): if the grant was already registered, the tenure ends on the next cycle with no stb issued to the slave.
- Simultaneous requests: exactly one grant. Over K rounds with all masters continuously requesting, each master receives a grant every NUM_MASTERS tenures.
- Reset mid-tenure: all outputs go to their reset values asynchronously. Masters re-request after reset.

Decomposition:
- Shared package wb_pkg holds:
  - the default bus widths (ADDR_WIDTH=32, DATA_WIDTH=128, SEL_WIDTH=16);
  - the arbiter state encoding (IDLE=2'd0, GRANT=2'd1, ABORT=2'd2).
- One natural sub-module, rr_pick: purely combinational rotating priority picker.
  - Inputs: request vector, pointer. Output: one-hot pick plus valid.
- The watchdog counter, FSM and muxes stay in the top level.

Test Plan:
- Single master 1 (N=2): cyc/stb at cycle 0, adr=0x0000_1000, slave ack at cycle 3 with s_dat_i=0xDEADBEEF_...:
  - grant_o=2'b10 at cycle 1, s_adr_o=0x1000;
  - m_ack_o=2'b10 at cycle 3, m_dat_o matches;
  - grant_o=0 one cycle after cyc drops.
- Both masters request in the same cycle after reset:
  - master 0 is granted first; after release, an idle cycle, then master 1 is granted.
  - m_ack_o[0] never asserts during master 1's tenure.
- Both request continuously for 8 tenures: grants alternate 01,10,01,…, each master exactly 4.
- TIMEOUT=4, slave never acks:
  - timeout_o pulses 4 cycles after s_stb_o rises, with m_err_o=granted bit and s_cyc_o=0 that cycle;
  - next cycle IDLE and the other master may be granted.
- rst asserted asynchronously mid-tenure (between clk edges): grant_o, s_cyc_o, s_stb_o drop to 0 immediately; after release, the first request is served with priority to master 0.
- Master holds cyc across 3 stb beats (burst), second master requesting throughout: grant stays with the first master for all 3 acks, and passes only after its cyc drops.
